// File: rtl/ps2_frame_rx.sv
// ============================================================================
// Module   : ps2_frame_rx
// Brief    : PS/2 device-to-host frame receiver with a glitch-filtered clock,
//            a framing check, a mid-frame watchdog and an error pulse.
//            The optional odd-parity check is enabled by PS2_PARITY_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_frame_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2d,
   input  logic       ps2c,
   input  logic       rx_en,
   output logic       rx_done_tick,
   output logic [7:0] dout,
   output logic       err_tick
);

   localparam int              WD_W       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX     = WD_W'(TIMEOUT_CYCLES);
   localparam logic [3:0]      FRAME_BITS = 4'd10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } state_t;

   logic                  ps2c_meta, ps2c_sync;
   logic                  ps2d_meta, ps2d_sync;
   logic [FILTER_LEN-1:0] filter_reg, filter_next;
   logic                  filt_clk, filt_next;
   logic                  fall;

   state_t                state, state_next;
   logic [3:0]            bit_cnt, bit_cnt_next;
   logic [10:0]           shreg, shreg_next;
   logic [WD_W-1:0]       wd, wd_next;
   logic [7:0]            dout_next;
   logic                  done_next, err_next;
   logic                  parity_ok, frame_ok;
   logic                  unused_bits;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ps2c_meta  <= 1'b1;
         ps2c_sync  <= 1'b1;
         ps2d_meta  <= 1'b1;
         ps2d_sync  <= 1'b1;
         filter_reg <= '1;
         filt_clk   <= 1'b1;
      end else begin
         ps2c_meta  <= ps2c;
         ps2c_sync  <= ps2c_meta;
         ps2d_meta  <= ps2d;
         ps2d_sync  <= ps2d_meta;
         filter_reg <= filter_next;
         filt_clk   <= filt_next;
      end
   end

   // Filtered clock only moves once the whole window agrees, so short pulses are swallowed.
   always_comb begin
      filter_next = {filter_reg[FILTER_LEN-2:0], ps2c_sync};
      filt_next   = filt_clk;
      if (filter_reg == '1)
         filt_next = 1'b1;
      else if (filter_reg == '0)
         filt_next = 1'b0;
   end

   assign fall = filt_clk & ~filt_next;

`ifdef PS2_PARITY_CHECK_EN
   assign parity_ok = ^shreg[9:1];
`else
   assign parity_ok = 1'b1;
`endif

   assign frame_ok    = shreg[10] & parity_ok;
   assign unused_bits = shreg[0] ^ shreg[9];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         bit_cnt      <= 4'd0;
         shreg        <= 11'd0;
         wd           <= '0;
         dout         <= 8'h00;
         rx_done_tick <= 1'b0;
         err_tick     <= 1'b0;
      end else begin
         state        <= state_next;
         bit_cnt      <= bit_cnt_next;
         shreg        <= shreg_next;
         wd           <= wd_next;
         dout         <= dout_next;
         rx_done_tick <= done_next;
         err_tick     <= err_next;
      end
   end

   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      shreg_next   = shreg;
      wd_next      = wd;
      dout_next    = dout;
      done_next    = 1'b0;
      err_next     = 1'b0;

      case (state)
         IDLE: begin
            if (fall && rx_en && !ps2d_sync) begin
               state_next   = RECV;
               bit_cnt_next = FRAME_BITS;
               wd_next      = '0;
            end
         end
         RECV: begin
            if (fall) begin
               shreg_next   = {ps2d_sync, shreg[10:1]};
               bit_cnt_next = bit_cnt - 4'd1;
               wd_next      = '0;
               if (bit_cnt == 4'd1)
                  state_next = CHECK;
            end else if (wd == WD_MAX) begin
               // Device stalled mid-frame: drop the partial byte.
               state_next = IDLE;
               err_next   = 1'b1;
            end else begin
               wd_next = wd + 1'b1;
            end
         end
         CHECK: begin
            state_next = IDLE;
            if (frame_ok) begin
               dout_next = shreg[8:1];
               done_next = 1'b1;
            end else begin
               err_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_ps2_frame_rx.sv
// ============================================================================
// Module   : tb_ps2_frame_rx
// Brief    : Scoreboard bench for ps2_frame_rx; follows PS2_PARITY_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_frame_rx;

   localparam int FILTER_LEN     = 8;
   localparam int TIMEOUT_CYCLES = 500;
   localparam int HALF           = 40;   // PS/2 half bit period in clk cycles (scaled down)

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2d;
   logic       ps2c;
   logic       rx_en;
   logic       rx_done_tick;
   logic [7:0] dout;
   logic       err_tick;

   typedef struct {
      logic       is_err;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         n_done   = 0;
   int         n_err    = 0;
   int         exp_done = 0;
   int         exp_err  = 0;
   logic [7:0] exp_dout = 8'h00;

   ps2_frame_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ps2d         (ps2d),
      .ps2c         (ps2c),
      .rx_en        (rx_en),
      .rx_done_tick (rx_done_tick),
      .dout         (dout),
      .err_tick     (err_tick)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_good(input logic [7:0] data);
      exp_t e;
      e.is_err = 1'b0;
      e.data   = data;
      sb.push_back(e);
      exp_dout = data;
      exp_done++;
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1;
      e.data   = exp_dout;
      sb.push_back(e);
      exp_err++;
   endtask

   // Drives the first nbits of {stop, parity, data, start}, LSB first.
   task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                             input int nbits);
      logic [10:0] bits;
      bits = {stop, par, data, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2d = bits[i];
         repeat (HALF) @(negedge clk);
         ps2c = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2c = 1'b1;
      end
      ps2d = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic send_good(input logic [7:0] data);
      push_good(data);
      send_frame(data, ~^data, 1'b1, 11);
   endtask

   always @(negedge clk) begin
      if (!reset && (rx_done_tick || err_tick)) begin
         exp_t e;
         check_eq("tick_exclusive", {31'd0, rx_done_tick & err_tick}, 32'd0);
         if (rx_done_tick) n_done++;
         if (err_tick)     n_err++;
         check_eq("event_expected", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("event_kind", {31'd0, err_tick}, {31'd0, e.is_err});
            check_eq("dout", {24'd0, dout}, {24'd0, e.data});
         end
      end
   end

   initial begin
      reset = 1'b1;
      ps2c  = 1'b1;
      ps2d  = 1'b1;
      rx_en = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("rst_dout", {24'd0, dout}, 32'd0);
      check_eq("rst_done", {31'd0, rx_done_tick}, 32'd0);
      check_eq("rst_err", {31'd0, err_tick}, 32'd0);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      // Glitches one cycle shorter than the filter window.
      for (int g = 0; g < 3; g++) begin
         ps2c = 1'b0;
         repeat (FILTER_LEN - 1) @(negedge clk);
         ps2c = 1'b1;
         repeat (30) @(negedge clk);
      end
      check_eq("glitch_dout", {24'd0, dout}, 32'd0);

      send_good(8'h1C);
      send_good(8'hF0);
      send_good(8'h5A);

      push_err();
      send_frame(8'h23, ~^8'h23, 1'b0, 11);
      send_good(8'h23);

      // Stall after start + 4 data bits.
      push_err();
      send_frame(8'h1C, 1'b0, 1'b1, 5);
      repeat (TIMEOUT_CYCLES + 10) @(negedge clk);
      send_good(8'h1C);

      // 0x1C with parity bit 1 (wrong for odd parity).
`ifdef PS2_PARITY_CHECK_EN
      push_err();
`else
      push_good(8'h1C);
`endif
      send_frame(8'h1C, 1'b1, 1'b1, 11);

      // Asynchronous reset part-way through a frame.
      send_frame(8'hA5, ~^8'hA5, 1'b1, 6);
      #2 reset = 1'b1;
      #1;
      exp_dout = 8'h00;
      check_eq("async_rst_dout", {24'd0, dout}, 32'd0);
      check_eq("async_rst_done", {31'd0, rx_done_tick}, 32'd0);
      check_eq("async_rst_err", {31'd0, err_tick}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      send_good(8'h5A);

      check_eq("sb_empty", sb.size(), 32'd0);
      check_eq("done_count", n_done, exp_done);
      check_eq("err_count", n_err, exp_err);
      check_eq("final_dout", {24'd0, dout}, {24'd0, exp_dout});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
